// File: rtl/uart_frame_loader_if.sv
// Receive-byte stream, memory write bus and frame status of the UART frame loader.
// The master modport is the loader side; the slave modport is the receiver/memory side.
interface uart_frame_loader_if #(
  parameter int AW = 16
);
  logic [7:0]    rx_byte;
  logic          rx_rdy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          frame_ok;
  logic          frame_err;
  logic [1:0]    err_code;

  modport master (
    input  rx_byte, rx_rdy, mem_ack,
    output mem_req, mem_addr, mem_wdata, busy, frame_ok, frame_err, err_code
  );

  modport slave (
    output rx_byte, rx_rdy, mem_ack,
    input  mem_req, mem_addr, mem_wdata, busy, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Parses framed write commands (A5, ADDR_HI, ADDR_LO, LEN, data..., CHK) from the UART
// receive stream, issues one req/ack memory write per data byte and reports the outcome.
module uart_frame_loader #(
  parameter int AW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               res,
  uart_frame_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDRH = 3'd1,
    S_ADDRL = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_WRITE = 3'd5,
    S_CHK   = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_OVR  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [7:0]    hi_q,    hi_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic [7:0]    sum_q,   sum_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          req_q,   req_d;
  logic          ok_q,    ok_d;
  logic          err_q,   err_d;
  logic [1:0]    code_q,  code_d;
  logic          ovr_q,   ovr_d;
  logic [9:0]    tmo_q,   tmo_d;
  logic          busy_q,  busy_d;
  logic          tmo_run_s;
  logic          tmo_hit_s;

  // Next-state, datapath and status computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    ovr_d   = ovr_q;

    // The inter-byte timer is frozen while a write is outstanding.
    tmo_run_s = (state_q != S_IDLE) && (state_q != S_WRITE);
    tmo_hit_s = tmo_run_s && !bus.rx_rdy && (tmo_q == TMO_LAST);

    if (bus.rx_rdy) begin
      tmo_d = 10'd0;
    end else if (tmo_run_s) begin
      tmo_d = tmo_q + 10'd1;
    end else if (state_q == S_IDLE) begin
      tmo_d = 10'd0;
    end else begin
      tmo_d = tmo_q;
    end

    if (tmo_hit_s) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_rdy && (bus.rx_byte == SYNC_BYTE)) begin
            state_d = S_ADDRH;
            code_d  = ERR_NONE;
            sum_d   = 8'h00;
            ovr_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDRH: begin
          if (bus.rx_rdy) begin
            hi_d    = bus.rx_byte;
            sum_d   = csum_add(sum_q, bus.rx_byte);
            state_d = S_ADDRL;
          end else begin
            state_d = S_ADDRH;
          end
        end
        S_ADDRL: begin
          if (bus.rx_rdy) begin
            addr_d  = AW'({hi_q, bus.rx_byte});
            sum_d   = csum_add(sum_q, bus.rx_byte);
            state_d = S_LEN;
          end else begin
            state_d = S_ADDRL;
          end
        end
        S_LEN: begin
          if (bus.rx_rdy) begin
            cnt_d   = bus.rx_byte;
            sum_d   = csum_add(sum_q, bus.rx_byte);
            state_d = (bus.rx_byte == 8'h00) ? S_CHK : S_DATA;
          end else begin
            state_d = S_LEN;
          end
        end
        S_DATA: begin
          if (bus.rx_rdy) begin
            wdata_d = bus.rx_byte;
            sum_d   = csum_add(sum_q, bus.rx_byte);
            req_d   = 1'b1;
            state_d = S_WRITE;
          end else begin
            state_d = S_DATA;
          end
        end
        S_WRITE: begin
          // A byte landing during the write is lost; the write itself still completes.
          if (bus.rx_rdy) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
          if (bus.mem_ack) begin
            req_d  = 1'b0;
            addr_d = addr_q + AW'(1'b1);
            cnt_d  = cnt_q - 8'd1;
            if (ovr_q || bus.rx_rdy) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_OVR;
            end else if (cnt_q == 8'd1) begin
              state_d = S_CHK;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_WRITE;
          end
        end
        S_CHK: begin
          if (bus.rx_rdy) begin
            state_d = S_IDLE;
            if (bus.rx_byte == sum_q) begin
              ok_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_CHK;
            end
          end else begin
            state_d = S_CHK;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any pending request immediately.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hi_q    <= 8'h00;
      cnt_q   <= 8'h00;
      sum_q   <= 8'h00;
      wdata_q <= 8'h00;
      req_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ovr_q   <= 1'b0;
      tmo_q   <= 10'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.frame_ok  = ok_q;
  assign bus.frame_err = err_q;
  assign bus.err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: expected writes and frame results are queued
// as bytes are sent and checked when the loader issues them.
module tb_uart_frame_loader;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  uart_frame_loader_if #(.AW(AW)) bus ();

  uart_frame_loader #(.AW(AW), .TIMEOUT(1023)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] sb_wr[$];   // {addr, data}
  logic [3:0]  sb_res[$];  // {frame_ok, frame_err, err_code}
  logic [7:0]  fd[$];

  int ack_delay = 0;
  bit ack_hold  = 1'b0;
  int wcnt      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // memory side: acknowledge after ack_delay cycles unless held off
  always begin
    @(posedge clk);
    #2;
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end else if (bus.mem_req && !ack_hold) begin
      if (wcnt >= ack_delay) bus.mem_ack = 1'b1;
      else wcnt++;
    end else if (!bus.mem_req) begin
      wcnt = 0;
    end
  end

  // monitor: compare every request cycle and every completion pulse against the scoreboard
  always @(negedge clk) begin
    if (!res) begin
      if (bus.mem_req) begin
        if (sb_wr.size() == 0) begin
          check_eq("req_unexp", {31'd0, bus.mem_req}, 32'd0);
        end else begin
          check_eq("wr_addr", {16'd0, bus.mem_addr}, {16'd0, sb_wr[0][23:8]});
          check_eq("wr_data", {24'd0, bus.mem_wdata}, {24'd0, sb_wr[0][7:0]});
          if (bus.mem_ack) void'(sb_wr.pop_front());
        end
      end
      if (bus.frame_ok || bus.frame_err) begin
        if (sb_res.size() == 0) begin
          check_eq("pulse_unexp", {30'd0, bus.frame_ok, bus.frame_err}, 32'd0);
        end else begin
          check_eq("result", {28'd0, bus.frame_ok, bus.frame_err, bus.err_code},
                   {28'd0, sb_res.pop_front()});
          check_eq("busy_at_end", {31'd0, bus.busy}, 32'd0);
        end
      end
    end
  end

  task automatic tx(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_byte = b;
    bus.rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_rdy  = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // builds the frame from fd, queues its writes and outcome, then sends it
  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] delta);
    logic [7:0]  s;
    logic [15:0] a;
    logic [7:0]  len;
    len = 8'(fd.size());
    s   = hi + lo + len;
    a   = {hi, lo};
    foreach (fd[i]) begin
      sb_wr.push_back({a, fd[i]});
      a = a + 16'd1;
      s = s + fd[i];
    end
    sb_res.push_back((delta == 8'h00) ? 4'b1000 : 4'b0101);
    tx(8'hA5);
    tx(hi);
    tx(lo);
    tx(len);
    foreach (fd[i]) tx(fd[i]);
    tx(s + delta);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb_res.size() != 0; i++) @(posedge clk);
    check_eq("frame_done", sb_res.size(), 32'd0);
    check_eq("writes_left", sb_wr.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res         = 1'b1;
    bus.rx_byte = 8'h00;
    bus.rx_rdy  = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req",  {31'd0, bus.mem_req}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_ok",   {31'd0, bus.frame_ok}, 32'd0);
    check_eq("rst_err",  {31'd0, bus.frame_err}, 32'd0);
    check_eq("rst_code", {30'd0, bus.err_code}, 32'd0);
    check_eq("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
    res = 1'b0;
    repeat (3) @(posedge clk);

    // basic frame: A5 12 34 02 AA 55 47
    fd = {8'hAA, 8'h55};
    send_frame(8'h12, 8'h34, 8'h00);
    wait_done(50);
    check_eq("basic_code", {30'd0, bus.err_code}, 32'd0);
    check_eq("basic_busy", {31'd0, bus.busy}, 32'd0);

    // bad checksum: CHK = 48, writes still happen
    send_frame(8'h12, 8'h34, 8'h01);
    wait_done(50);
    repeat (20) @(posedge clk);
    check_eq("chk_code_hold", {30'd0, bus.err_code}, 32'd1);

    // zero length: A5 00 00 00 00, sync clears err_code
    sb_res.push_back(4'b1000);
    tx(8'hA5);
    check_eq("sync_code_clr", {30'd0, bus.err_code}, 32'd0);
    check_eq("sync_busy", {31'd0, bus.busy}, 32'd1);
    tx(8'h00);
    tx(8'h00);
    tx(8'h00);
    tx(8'h00);
    wait_done(50);

    // address wrap with slow ack: A5 FF FF 02 01 02 03
    ack_delay = 5;
    fd = {8'h01, 8'h02};
    send_frame(8'hFF, 8'hFF, 8'h00);
    wait_done(100);
    ack_delay = 0;

    // timeout after A5 00 10
    sb_res.push_back(4'b0111);
    tx(8'hA5);
    tx(8'h00);
    tx(8'h10);
    repeat (1000) @(posedge clk);
    check_eq("tmo_early", sb_res.size(), 32'd1);
    wait_done(100);
    check_eq("tmo_code", {30'd0, bus.err_code}, 32'd3);
    fd = {8'hC3};
    send_frame(8'h40, 8'h00, 8'h00);
    wait_done(50);

    // overrun: byte arrives while the write is still pending
    ack_hold = 1'b1;
    sb_wr.push_back({16'h0020, 8'h11});
    sb_res.push_back(4'b0110);
    tx(8'hA5);
    tx(8'h00);
    tx(8'h20);
    tx(8'h02);
    tx(8'h11);
    check_eq("ovr_req_held", {31'd0, bus.mem_req}, 32'd1);
    tx(8'h22);
    check_eq("ovr_req_still", {31'd0, bus.mem_req}, 32'd1);
    check_eq("ovr_busy", {31'd0, bus.busy}, 32'd1);
    ack_hold = 1'b0;
    wait_done(50);
    check_eq("ovr_code", {30'd0, bus.err_code}, 32'd2);

    // reset while a write is pending: request drops asynchronously, no pulse
    ack_hold = 1'b1;
    sb_wr.push_back({16'h0030, 8'h77});
    tx(8'hA5);
    tx(8'h00);
    tx(8'h30);
    tx(8'h01);
    tx(8'h77);
    check_eq("rstw_req_before", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk);
    #3;
    res = 1'b1;
    #1;
    check_eq("rstw_req_async", {31'd0, bus.mem_req}, 32'd0);
    check_eq("rstw_busy", {31'd0, bus.busy}, 32'd0);
    sb_wr.delete();
    @(posedge clk);
    #3;
    res = 1'b0;
    ack_hold = 1'b0;
    repeat (30) @(posedge clk);
    check_eq("rstw_idle_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rstw_code", {30'd0, bus.err_code}, 32'd0);

    // loader is back in IDLE and accepts a fresh frame
    fd = {8'h5A};
    send_frame(8'h00, 8'h40, 8'h00);
    wait_done(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
